// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Alarm scheduler for the digital clock. It watches the BCD time from the time
// counter and holds a programmable alarm time. It sequences the set, ring,
// snooze and stop flow, drives the buzzer pattern and raises an hourly chime.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   sec_tick   one-cycle pulse once per second
//   hour       current hour, BCD 00..23
//   minute     current minute, BCD 00..59
//   second     current second, BCD 00..59
//   set_en     level, high selects alarm-set mode
//   sel        pulse, toggles the field being set
//   inc        pulse, increments the selected field
//   arm        pulse, toggles alarm enable (disarms and stops while active)
//   snooze     pulse, snoozes a ringing alarm
//   stop       pulse, stops a ringing or snoozed alarm
//   al_hour    alarm hour, BCD
//   al_minute  alarm minute, BCD
//   armed      alarm enabled
//   set_field  0 = hour selected, 1 = minute selected
//   ringing    high while ringing
//   snoozing   high while snoozed
//   alert      buzzer drive, 1 s on / 1 s off while ringing
//   chime      hourly chime drive
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int CHIME_SECS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       set_en,
  input  logic       sel,
  input  logic       inc,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] al_hour,
  output logic [7:0] al_minute,
  output logic       armed,
  output logic       set_field,
  output logic       ringing,
  output logic       snoozing,
  output logic       alert,
  output logic       chime
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(MAX_SNOOZE + 1);
  localparam int CW = $clog2(CHIME_SECS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET,
    ST_RING,
    ST_SNOOZE
  } state_e;

  // BCD increment that wraps from max_v back to 00 without carrying out.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  // Current hour:minute plus SNOOZE_MIN, carrying into the hour and wrapping
  // 23 -> 00. Done in binary because a BCD adder with carry is harder to read.
  function automatic logic [15:0] snooze_target(input logic [7:0] h, input logic [7:0] m);
    logic [6:0] hb;
    logic [6:0] mb;
    hb = bcd2bin(h);
    mb = bcd2bin(m) + 7'(SNOOZE_MIN);
    if (mb >= 7'd60) begin
      mb = mb - 7'd60;
      hb = (hb == 7'd23) ? 7'd0 : hb + 7'd1;
    end
    return {bin2bcd(hb), bin2bcd(mb)};
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      al_hour_q, al_hour_d;
  logic [7:0]      al_minute_q, al_minute_d;
  logic [7:0]      sn_hour_q, sn_hour_d;
  logic [7:0]      sn_minute_q, sn_minute_d;
  logic            armed_q, armed_d;
  logic            set_field_q, set_field_d;
  logic            ringing_q, ringing_d;
  logic            snoozing_q, snoozing_d;
  logic            alert_q, alert_d;
  logic            chime_q, chime_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic [CW-1:0]   chime_cnt_q, chime_cnt_d;
  logic            alm_q, snm_q, hb_q;

  logic            alm, snm, hb;
  logic            alm_rise, snm_rise, hb_rise;
  logic            to_idle;

  // Match conditions are registered every cycle, in every state, so a match
  // window that was already open (for example while in SET) never produces an
  // edge afterwards.
  assign alm = armed_q && (hour == al_hour_q) && (minute == al_minute_q) && (second == 8'h00);
  assign snm = (hour == sn_hour_q) && (minute == sn_minute_q) && (second == 8'h00);
  assign hb  = (minute == 8'h00) && (second == 8'h00);

  assign alm_rise = alm && !alm_q;
  assign snm_rise = snm && !snm_q;
  assign hb_rise  = hb && !hb_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // and infers a latch; combinational logic uses blocking '=' throughout.
    state_d      = state_q;
    al_hour_d    = al_hour_q;
    al_minute_d  = al_minute_q;
    sn_hour_d    = sn_hour_q;
    sn_minute_d  = sn_minute_q;
    armed_d      = armed_q;
    set_field_d  = set_field_q;
    ringing_d    = ringing_q;
    snoozing_d   = snoozing_q;
    alert_d      = alert_q;
    chime_d      = chime_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    chime_cnt_d  = chime_cnt_q;
    to_idle      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) armed_d = !armed_q;
        if (set_en) begin
          state_d = ST_SET;
        end else if (alm_rise) begin
          state_d      = ST_RING;
          ringing_d    = 1'b1;
          alert_d      = 1'b1;
          ring_cnt_d   = '0;
          snooze_cnt_d = '0;
        end
      end

      ST_SET: begin
        if (arm) armed_d = !armed_q;
        if (!set_en) begin
          state_d     = ST_IDLE;
          set_field_d = 1'b0;
        end else begin
          if (sel) set_field_d = !set_field_q;
          // inc acts on the field selected before any same-cycle sel.
          if (inc) begin
            if (set_field_q) al_minute_d = bcd_inc(al_minute_q, 8'h59);
            else             al_hour_d   = bcd_inc(al_hour_q, 8'h23);
          end
        end
      end

      ST_RING: begin
        if (arm || stop) begin
          to_idle = 1'b1;
          if (arm) armed_d = 1'b0;
        end else if (snooze) begin
          if (snooze_cnt_q < SW'(MAX_SNOOZE)) begin
            state_d                  = ST_SNOOZE;
            ringing_d                = 1'b0;
            snoozing_d               = 1'b1;
            alert_d                  = 1'b0;
            {sn_hour_d, sn_minute_d} = snooze_target(hour, minute);
            snooze_cnt_d             = snooze_cnt_q + SW'(1);
          end else begin
            to_idle = 1'b1;
          end
        end else if (sec_tick) begin
          if (ring_cnt_q == RW'(RING_SECS - 1)) begin
            to_idle = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + RW'(1);
            alert_d    = !alert_q;
          end
        end
      end

      ST_SNOOZE: begin
        if (arm || stop) begin
          to_idle = 1'b1;
          if (arm) armed_d = 1'b0;
        end else if (snm_rise) begin
          state_d    = ST_RING;
          ringing_d  = 1'b1;
          snoozing_d = 1'b0;
          alert_d    = 1'b1;
          ring_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (to_idle) begin
      state_d    = ST_IDLE;
      ringing_d  = 1'b0;
      snoozing_d = 1'b0;
      alert_d    = 1'b0;
    end

    // The chime looks at the next state so that an alarm firing on the hour
    // boundary wins, and entering SET never leaves a stale chime behind.
    if (state_d == ST_RING || state_d == ST_SET) begin
      chime_d     = 1'b0;
      chime_cnt_d = '0;
    end else if (hb_rise && (state_q == ST_IDLE || state_q == ST_SNOOZE)) begin
      chime_d     = 1'b1;
      chime_cnt_d = '0;
    end else if (chime_q && sec_tick) begin
      if (chime_cnt_q == CW'(CHIME_SECS - 1)) begin
        chime_d     = 1'b0;
        chime_cnt_d = '0;
      end else begin
        chime_cnt_d = chime_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      al_hour_q    <= 8'h07;
      al_minute_q  <= 8'h00;
      sn_hour_q    <= 8'h00;
      sn_minute_q  <= 8'h00;
      armed_q      <= 1'b0;
      set_field_q  <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
      alert_q      <= 1'b0;
      chime_q      <= 1'b0;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      chime_cnt_q  <= '0;
      alm_q        <= 1'b0;
      snm_q        <= 1'b0;
      hb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      al_hour_q    <= al_hour_d;
      al_minute_q  <= al_minute_d;
      sn_hour_q    <= sn_hour_d;
      sn_minute_q  <= sn_minute_d;
      armed_q      <= armed_d;
      set_field_q  <= set_field_d;
      ringing_q    <= ringing_d;
      snoozing_q   <= snoozing_d;
      alert_q      <= alert_d;
      chime_q      <= chime_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      chime_cnt_q  <= chime_cnt_d;
      alm_q        <= alm;
      snm_q        <= snm;
      hb_q         <= hb;
    end
  end

  assign al_hour   = al_hour_q;
  assign al_minute = al_minute_q;
  assign armed     = armed_q;
  assign set_field = set_field_q;
  assign ringing   = ringing_q;
  assign snoozing  = snoozing_q;
  assign alert     = alert_q;
  assign chime     = chime_q;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Alarm scheduler for the digital clock. It watches the BCD time coming out of the time counter, holds a programmable alarm time, and sequences the set, ring, snooze and stop flow. It also drives the buzzer pattern and an hourly chime. It sits beside the existing control block and consumes the counter's hour/minute/second buses plus a one-second tick.

Parameters:
RING_SECS, 60, sec_tick pulses in RING before automatic return to IDLE
SNOOZE_MIN, 5, minutes added to current time on snooze (1..9)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses act as stop
CHIME_SECS, 4, sec_tick pulses the chime output stays high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sec_tick  in  1  one-cycle pulse once per second, synchronous to clk
hour  in  8  current hour, BCD 00..23
minute  in  8  current minute, BCD 00..59
second  in  8  current second, BCD 00..59
set_en  in  1  level; high selects alarm-set mode
sel  in  1  one-cycle pulse; toggles the field being set
inc  in  1  one-cycle pulse; increments the selected field
arm  in  1  one-cycle pulse; toggles alarm enable
snooze  in  1  one-cycle pulse
stop  in  1  one-cycle pulse
al_hour  out  8  alarm hour, BCD
al_minute  out  8  alarm minute, BCD
armed  out  1  alarm enabled
set_field  out  1  0 = hour selected, 1 = minute selected
ringing  out  1  high in RING
snoozing  out  1  high in SNOOZE
alert  out  1  buzzer drive
chime  out  1  hourly chime drive

Behaviour:
- Reset (reset=0, async) values: state IDLE; al_hour=8'h07; al_minute=8'h00; armed=0; set_field=0; ringing=0; snoozing=0; alert=0; chime=0; snooze count=0; match-edge registers=0. All outputs are registered.
- FSM states: IDLE, SET, RING, SNOOZE.
- IDLE -> SET when set_en=1. SET -> IDLE when set_en=0, and set_field returns to 0. set_en is ignored in RING and SNOOZE.
- SET:
  - sel toggles set_field.
  - inc increments the selected field as a BCD value.
  - Hour wraps 23 -> 00. Minute wraps 59 -> 00 with no carry into hour.
  - Hour step 09 -> 10 is a BCD step, never 0A.
  - Updated value appears on the cycle after the inc pulse.
- Alarm match: alm = armed & hour==al_hour & minute==al_minute & second==8'h00. Register alm each cycle.
  - IDLE -> RING on the rising edge of alm (alm=1, previous value 0).
  - Entry clears the snooze count.
  - Match is not evaluated in SET; a match window spanning SET exit does not fire.
- RING:
  - ringing=1.
  - alert=1 on entry, then toggles on every sec_tick, giving 1 s on / 1 s off.
  - Ring counter increments on sec_tick.
  - After RING_SECS ticks: -> IDLE.
- RING exits on inputs:
  - stop -> IDLE.
  - snooze with count < MAX_SNOOZE -> SNOOZE. Capture the snooze target as current hour:minute + SNOOZE_MIN, BCD, with minute carry into hour and hour wrap 23 -> 00 (e.g. 23:58 + 5 = 00:03). Increment the snooze count.
  - snooze with count = MAX_SNOOZE behaves as stop.
  - stop and snooze in the same cycle: stop wins.
- SNOOZE:
  - snoozing=1, alert=0.
  - Rising edge of (hour==sn_hour & minute==sn_minute & second==00) -> RING. Snooze count is kept, ring counter restarts, alert restarts at 1.
  - stop -> IDLE.
- arm pulse:
  - In IDLE/SET: toggles armed.
  - In RING/SNOOZE: clears armed and goes to IDLE.
  - arm and stop in the same cycle: net result is armed=0, IDLE.
- On every transition into IDLE, alert=0, ringing=0, snoozing=0.
- Chime:
  - Starts on the rising edge of (minute==00 & second==00) while state is IDLE or SNOOZE.
  - chime stays high for CHIME_SECS sec_tick pulses.
  - Suppressed, and cleared if active, whenever the state is RING or SET.
  - If the alarm and the hour boundary coincide, RING takes priority and chime stays 0.
- Latency: an input pulse or match edge is reflected in the outputs on the next clk edge.
- Reset mid-RING or mid-SET returns immediately to the reset values. A programmed alarm time is lost.

Test Plan:
- Reset, then 7 inc pulses in SET hour field: al_hour 07 -> 14. Then sel, 61 inc pulses: al_minute=01 (wrap at 59); al_hour unchanged.
- Arm, alarm 06:30, time stepped 06:29:59 -> 06:30:00: ringing=1 next cycle, alert=1. alert toggles on each sec_tick. After 60 ticks, IDLE with alert=0.
- Alarm 23:58 ringing, snooze pulse: snoozing=1. Advance time to 00:03:00: RING re-entered. Three snoozes accepted; the fourth snooze returns to IDLE.
- stop and snooze asserted in the same RING cycle: IDLE, snoozing=0. arm pulse during SNOOZE: armed=0, IDLE. A later 00:03:00 does not ring.
- Time 10:59:59 -> 11:00:00 in IDLE: chime=1 for exactly 4 sec_ticks. Same boundary with the alarm at 11:00 armed: ringing=1, chime=0.
- Drive reset low while ringing and while in SET: all outputs at reset values asynchronously; al_hour=07, al_minute=00.
